// File: rtl/serial_pkt_ctrl_if.sv
// Byte-stream and packet-status bundle between the serial receiver, the packet
// controller and the downstream byte consumer.
interface serial_pkt_ctrl_if;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic [7:0] out_byte;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       pkt_ok;
    logic       pkt_err;
    logic [2:0] err_code;
    logic       busy;

    // slave: the packet controller itself
    modport slave (
        input  rx_byte, rx_done, out_ready,
        output out_byte, out_last, out_valid, pkt_ok, pkt_err, err_code, busy
    );

    // master: the surrounding receiver/consumer environment
    modport master (
        output rx_byte, rx_done, out_ready,
        input  out_byte, out_last, out_valid, pkt_ok, pkt_err, err_code, busy
    );
endinterface

// File: rtl/serial_pkt_ctrl.sv
// Sync-hunting, length-prefixed frame parser feeding a payload FIFO with per-packet status.
// Optional inter-byte timeout enabled by defining SERIAL_PKT_TIMEOUT_EN.
module serial_pkt_ctrl #(
    parameter logic [7:0] SYNC       = 8'hA5,
    parameter int         MAX_LEN    = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter int         TIMEOUT    = 200
) (
    input  logic              clk,
    input  logic              reset,
    serial_pkt_ctrl_if.slave  bus
);

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("serial_pkt_ctrl: FIFO_DEPTH must be a power of two >= 2");
        end
        if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
            $error("serial_pkt_ctrl: MAX_LEN must be in 1..255");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("serial_pkt_ctrl: TIMEOUT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  count_reg, count_next;
    logic [7:0]  sum_reg, sum_next;
    logic        ovf_reg, ovf_next;
    logic        pkt_ok_reg, pkt_ok_next;
    logic        pkt_err_reg, pkt_err_next;
    logic [2:0]  err_code_reg, err_code_next;

    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [8:0]  mem [FIFO_DEPTH];
    logic        fifo_empty, fifo_full;
    logic        push_req, push, pop;
    logic [7:0]  csum_total;
    logic        timeout_hit;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop        = !fifo_empty && bus.out_ready;
    assign push       = push_req && (!fifo_full || pop);
    assign csum_total = sum_reg + bus.rx_byte;

`ifdef SERIAL_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_reg;

    // Fires on the TIMEOUT-th consecutive silent cycle since the last byte.
    assign timeout_hit = (state_reg != S_HUNT) && !bus.rx_done &&
                         (idle_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_reg <= '0;
        end else if (state_reg == S_HUNT || bus.rx_done || timeout_hit) begin
            idle_reg <= '0;
        end else begin
            idle_reg <= idle_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        sum_next      = sum_reg;
        ovf_next      = ovf_reg;
        pkt_ok_next   = 1'b0;
        pkt_err_next  = 1'b0;
        err_code_next = err_code_reg;
        push_req      = 1'b0;

        if (timeout_hit) begin
            pkt_err_next  = 1'b1;
            err_code_next = 3'd4;
            ovf_next      = 1'b0;
            count_next    = 8'd0;
            sum_next      = 8'd0;
            state_next    = S_HUNT;
        end else if (bus.rx_done) begin
            case (state_reg)
                S_HUNT: begin
                    if (bus.rx_byte == SYNC) begin
                        state_next = S_LEN;
                    end
                end
                S_LEN: begin
                    // A SYNC value here is a length, not a resync.
                    if (bus.rx_byte == 8'd0 || bus.rx_byte > MAX_LEN_B) begin
                        pkt_err_next  = 1'b1;
                        err_code_next = 3'd1;
                        state_next    = S_HUNT;
                    end else begin
                        count_next = bus.rx_byte;
                        sum_next   = bus.rx_byte;
                        state_next = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    push_req   = 1'b1;
                    sum_next   = sum_reg + bus.rx_byte;
                    count_next = count_reg - 8'd1;
                    // Parsing carries on through an overflow; the verdict comes at CSUM.
                    if (fifo_full && !pop) begin
                        ovf_next = 1'b1;
                    end
                    if (count_reg == 8'd1) begin
                        state_next = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (ovf_reg) begin
                        pkt_err_next  = 1'b1;
                        err_code_next = 3'd3;
                    end else if (csum_total == 8'd0) begin
                        pkt_ok_next   = 1'b1;
                        err_code_next = 3'd0;
                    end else begin
                        pkt_err_next  = 1'b1;
                        err_code_next = 3'd2;
                    end
                    ovf_next   = 1'b0;
                    count_next = 8'd0;
                    sum_next   = 8'd0;
                    state_next = S_HUNT;
                end
                default: begin
                    state_next = S_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_HUNT;
            count_reg    <= 8'd0;
            sum_reg      <= 8'd0;
            ovf_reg      <= 1'b0;
            pkt_ok_reg   <= 1'b0;
            pkt_err_reg  <= 1'b0;
            err_code_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            sum_reg      <= sum_next;
            ovf_reg      <= ovf_next;
            pkt_ok_reg   <= pkt_ok_next;
            pkt_err_reg  <= pkt_err_next;
            err_code_reg <= err_code_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= {(count_reg == 8'd1), bus.rx_byte};
        end
    end

    assign bus.out_valid = !fifo_empty;
    assign bus.out_byte  = fifo_empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]][7:0];
    assign bus.out_last  = fifo_empty ? 1'b0  : mem[rd_ptr_reg[AW-1:0]][8];
    assign bus.pkt_ok    = pkt_ok_reg;
    assign bus.pkt_err   = pkt_err_reg;
    assign bus.err_code  = err_code_reg;
    assign bus.busy      = (state_reg != S_HUNT);

endmodule

// File: tb/tb_serial_pkt_ctrl.sv
// Directed and randomized frames checked against a frame-level reference model
// (expected payload queue plus checksum/length rules computed per frame).
module tb_serial_pkt_ctrl;

    localparam logic [7:0] SYNC       = 8'hA5;
    localparam int         MAX_LEN    = 16;
    localparam int         FIFO_DEPTH = 4;
    localparam int         TIMEOUT    = 200;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    serial_pkt_ctrl_if bus ();

    serial_pkt_ctrl #(
        .SYNC      (SYNC),
        .MAX_LEN   (MAX_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         pulse_seen  = 0;
    int         pulse_exp   = 0;
    bit         rand_ready  = 1'b0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer-side monitor: every popped byte must be the next expected one.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            if (bus.pkt_ok || bus.pkt_err) pulse_seen++;
            check("pulse_exclusive", 32'(bus.pkt_ok & bus.pkt_err), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("pop_data", {23'd0, bus.out_last, bus.out_byte}, {23'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bus.rx_byte = b;
        bus.rx_done = 1'b1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.rx_byte = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
    endtask

    task automatic expect_status(input bit ok, input logic [2:0] code, input string tag);
        #1;
        check({tag, "_ok"},   32'(bus.pkt_ok),  32'(ok));
        check({tag, "_err"},  32'(bus.pkt_err), 32'(!ok));
        check({tag, "_code"}, 32'(bus.err_code), 32'(code));
        pulse_exp++;
        @(negedge clk);
        check({tag, "_width"}, 32'(bus.pkt_ok | bus.pkt_err), 32'd0);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(bus.out_valid), 32'd0);
    endtask

    function automatic logic [7:0] good_csum(input logic [7:0] len, input logic [7:0] pl[$]);
        int s = len;
        foreach (pl[i]) s += pl[i];
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // Reference: length rule first, then payload order with last flag, then checksum rule.
    task automatic run_frame(input string tag, input logic [7:0] len, input logic [7:0] pl[$],
                             input logic [7:0] csum, input int max_gap);
        int s;
        send(SYNC);
        send(len);
        if (len == 8'd0 || int'(len) > MAX_LEN) begin
            expect_status(1'b0, 3'd1, tag);
            return;
        end
        s = len;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({(i == int'(len) - 1), pl[i]});
            s += pl[i];
            idle($urandom_range(0, max_gap));
            send(pl[i]);
        end
        send(csum);
        if ((s + csum) % 256 == 0) expect_status(1'b1, 3'd0, tag);
        else                       expect_status(1'b0, 3'd2, tag);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] len;
        logic [7:0] cs;
        logic [7:0] g;
        int         first;
        logic [2:0] code;

        bus.rx_byte   = 8'h00;
        bus.rx_done   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_last",  32'(bus.out_last),  32'd0);
        check("rst_byte",  32'(bus.out_byte),  32'd0);
        check("rst_ok",    32'(bus.pkt_ok),    32'd0);
        check("rst_err",   32'(bus.pkt_err),   32'd0);
        check("rst_code",  32'(bus.err_code),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Good two-byte frame, then the same frame with a bad checksum
        pl = '{8'h10, 8'h20};
        run_frame("t1_good", 8'h02, pl, 8'hCE, 0);
        run_frame("t2_badcsum", 8'h02, pl, 8'hCF, 0);

        // Garbage before sync, zero length, then over-long length
        send(8'h00);
        send(8'h33);
        check("hunt_busy", 32'(bus.busy), 32'd0);
        pl = {};
        run_frame("t3_len0", 8'h00, pl, 8'h00, 0);
        check("t3_busy", 32'(bus.busy), 32'd0);
        run_frame("t3_len17", 8'h11, pl, 8'h00, 0);

        // Stalled consumer: only the first FIFO_DEPTH payload bytes survive
        bus.out_ready = 1'b0;
        send(SYNC);
        send(8'h06);
        for (int i = 1; i <= 6; i++) begin
            if (i <= FIFO_DEPTH) exp_q.push_back({1'b0, 8'(i)});
            send(8'(i));
        end
        send(8'hE5);
        expect_status(1'b0, 3'd3, "t4_ovf");
        check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
        check("t4_hold_byte",  32'(bus.out_byte),  32'h01);
        idle(3);
        check("t4_stable_byte", 32'(bus.out_byte), 32'h01);
        check("t4_stable_last", 32'(bus.out_last), 32'd0);
        drain();

        // SYNC-valued payload is data
        pl = '{SYNC, SYNC, SYNC};
        run_frame("t5_sync_data", 8'h03, pl, good_csum(8'h03, pl), 0);

        // Async reset in the middle of a payload
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h02});
        send(SYNC);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        #1;
        check("t6_busy_pre", 32'(bus.busy), 32'd1);
        check("t6_valid_pre", 32'(bus.out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_byte",  32'(bus.out_byte),  32'd0);
        check("t6_rst_last",  32'(bus.out_last),  32'd0);
        check("t6_rst_busy",  32'(bus.busy),      32'd0);
        check("t6_rst_ok",    32'(bus.pkt_ok),    32'd0);
        check("t6_rst_err",   32'(bus.pkt_err),   32'd0);
        check("t6_rst_code",  32'(bus.err_code),  32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pl = '{8'h77};
        run_frame("t6_after_rst", 8'h01, pl, good_csum(8'h01, pl), 0);

        // Random frames, always-ready consumer, gaps and back-to-back bytes
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 2)) begin
                do g = 8'($urandom); while (g == SYNC);
                send(g);
            end
            len = 8'($urandom_range(0, MAX_LEN + 3));
            pl  = {};
            if (len != 0 && int'(len) <= MAX_LEN)
                for (int i = 0; i < int'(len); i++)
                    pl.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
            cs = good_csum(len, pl);
            if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
            run_frame("rnd_ready", len, pl, cs, 2);
        end

        // Random frames with a randomly stalling consumer; short enough never to overflow
        rand_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            len = 8'($urandom_range(1, FIFO_DEPTH));
            pl  = {};
            for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom));
            cs = good_csum(len, pl);
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'h01;
            run_frame("rnd_stall", len, pl, cs, 1);
            drain();
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;

`ifdef SERIAL_PKT_TIMEOUT_EN
        exp_q.push_back({1'b0, 8'h10});
        send(SYNC);
        send(8'h02);
        send(8'h10);
        first = -1;
        code  = 3'd0;
        for (int k = 1; k <= TIMEOUT + 3; k++) begin
            @(negedge clk);
            #1;
            if (first < 0 && bus.pkt_err) begin
                first = k;
                code  = bus.err_code;
            end
        end
        check("timeout_cycles", 32'(first), 32'(TIMEOUT));
        check("timeout_code", 32'(code), 32'd4);
        check("timeout_busy", 32'(bus.busy), 32'd0);
        pulse_exp++;
        @(negedge clk);
        pl = '{8'h10, 8'h20};
        run_frame("timeout_recover", 8'h02, pl, 8'hCE, 0);
`else
        exp_q.push_back({1'b0, 8'h10});
        send(SYNC);
        send(8'h02);
        send(8'h10);
        repeat (1000) @(negedge clk);
        check("no_timeout_pulses", 32'(pulse_seen), 32'(pulse_exp));
        check("no_timeout_busy", 32'(bus.busy), 32'd1);
        exp_q.push_back({1'b1, 8'h20});
        send(8'h20);
        send(8'hCE);
        expect_status(1'b1, 3'd0, "no_timeout_finish");
`endif

        drain();
        check("pulse_count", 32'(pulse_seen), 32'(pulse_exp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
